// File: rtl/sme_host_driver.sv
// sme_host_driver: host-side initiator for the string-match engine.
// Loads string/pattern buffers over a config port, streams them to the SME on
// start, then waits for the SME valid strobe and captures its result.
// Optional feature macro: SME_DRV_TIMEOUT_EN. When it is defined, WAIT is
// bounded by TIMEOUT cycles and res_timeout reports an aborted transaction.
module sme_host_driver #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 9,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic       cfg_sel,
    input  logic [4:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    input  logic       send_str,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       match,
    input  logic [4:0] match_index,
    input  logic       valid
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_STR  = 3'd1;
    localparam logic [2:0] S_PAT  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [5:0] STR_MAX_L = 6'(STR_MAX);
    localparam logic [3:0] PAT_MAX_L = 4'(PAT_MAX);
    localparam logic [4:0] PAT_LIM_A = 5'(PAT_MAX);

    logic [7:0] str_buf [0:STR_MAX-1];
    logic [7:0] pat_buf [0:PAT_MAX-1];

    logic [2:0] state_reg;
    logic [5:0] cnt_reg;        // index of the next char to present
    logic [5:0] slen_reg;
    logic [3:0] plen_reg;
    logic       str_loaded_reg;

    logic [5:0] slen_eff;
    logic [3:0] plen_eff;
    logic       send_eff;
    logic [7:0] str_rd;
    logic [7:0] pat_rd;

    // Length clamping and first-char selection for an accepted start.
    always_comb begin
        slen_eff = str_len;
        if (str_len == 6'd0 || str_len > STR_MAX_L) begin
            slen_eff = STR_MAX_L;
        end
        plen_eff = pat_len;
        if (pat_len == 4'd0) begin
            plen_eff = 4'd1;
        end else if (pat_len > PAT_MAX_L) begin
            plen_eff = PAT_MAX_L;
        end
        // Without a string held by the SME, the string must go out again.
        send_eff = send_str | ~str_loaded_reg;
        str_rd   = str_buf[cnt_reg[4:0]];
        pat_rd   = pat_buf[cnt_reg[3:0]];
    end

    // Config writes into the char buffers; frozen while a transaction runs.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            if (!cfg_sel) begin
                str_buf[cfg_addr] <= cfg_data;
            end else if (cfg_addr < PAT_LIM_A) begin
                pat_buf[cfg_addr[3:0]] <= cfg_data;
            end
        end
    end

`ifdef SME_DRV_TIMEOUT_EN
    localparam logic [7:0] TO_L = 8'(TIMEOUT);
    logic [7:0] tcnt_reg;
    logic       res_timeout_reg;
    assign res_timeout = res_timeout_reg;
`else
    assign res_timeout = 1'b0;
`endif

    // Transaction sequencer: stream string, pattern, one blank gap, then wait for the SME result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 6'd0;
            slen_reg       <= 6'd0;
            plen_reg       <= 4'd0;
            str_loaded_reg <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            res_match      <= 1'b0;
            res_index      <= 5'd0;
            chardata       <= 8'd0;
            isstring       <= 1'b0;
            ispattern      <= 1'b0;
`ifdef SME_DRV_TIMEOUT_EN
            tcnt_reg        <= 8'd0;
            res_timeout_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        slen_reg <= slen_eff;
                        plen_reg <= plen_eff;
                        cnt_reg  <= 6'd1;
                        if (send_eff) begin
                            state_reg <= S_STR;
                            chardata  <= str_buf[0];
                            isstring  <= 1'b1;
                            ispattern <= 1'b0;
                        end else begin
                            state_reg <= S_PAT;
                            chardata  <= pat_buf[0];
                            isstring  <= 1'b0;
                            ispattern <= 1'b1;
                        end
                    end
                end
                S_STR: begin
                    if (cnt_reg == slen_reg) begin
                        // Last string char is on the wire; pattern follows with no gap.
                        state_reg      <= S_PAT;
                        str_loaded_reg <= 1'b1;
                        cnt_reg        <= 6'd1;
                        chardata       <= pat_buf[0];
                        isstring       <= 1'b0;
                        ispattern      <= 1'b1;
                    end else begin
                        cnt_reg  <= cnt_reg + 6'd1;
                        chardata <= str_rd;
                    end
                end
                S_PAT: begin
                    if (cnt_reg == {2'b00, plen_reg}) begin
                        state_reg <= S_GAP;
                        chardata  <= 8'd0;
                        isstring  <= 1'b0;
                        ispattern <= 1'b0;
                    end else begin
                        cnt_reg  <= cnt_reg + 6'd1;
                        chardata <= pat_rd;
                    end
                end
                S_GAP: begin
                    // Any valid seen up to here belongs to the previous transaction.
                    state_reg <= S_WAIT;
`ifdef SME_DRV_TIMEOUT_EN
                    tcnt_reg  <= 8'd0;
`endif
                end
                S_WAIT: begin
                    if (valid) begin
                        res_match <= match;
                        res_index <= match_index;
                        state_reg <= S_DONE;
                        done      <= 1'b1;
`ifdef SME_DRV_TIMEOUT_EN
                        res_timeout_reg <= 1'b0;
                    end else if (tcnt_reg == TO_L - 8'd1) begin
                        // WAIT has lasted TIMEOUT cycles: abort and force a string resend.
                        res_match       <= 1'b0;
                        res_index       <= 5'd0;
                        res_timeout_reg <= 1'b1;
                        str_loaded_reg  <= 1'b0;
                        state_reg       <= S_DONE;
                        done            <= 1'b1;
                    end else begin
                        tcnt_reg <= tcnt_reg + 8'd1;
`endif
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_host_driver.sv
// tb_sme_host_driver: self-checking bench for sme_host_driver.
// Directed spec sequences, a vector table and randomized transactions, all
// compared against shadow buffers and length rules kept in the bench.
module tb_sme_host_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we, cfg_sel, send_str, start;
    logic [4:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic       busy, done, res_match, res_timeout;
    logic [4:0] res_index;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       match, valid;
    logic [4:0] match_index;

    always #5 clk = ~clk;

    sme_host_driver dut (
        .clk(clk), .reset(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .str_len(str_len), .pat_len(pat_len), .send_str(send_str), .start(start),
        .busy(busy), .done(done), .res_match(res_match), .res_index(res_index),
        .res_timeout(res_timeout), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .match(match), .match_index(match_index), .valid(valid)
    );

    // Reference state: what the buffers hold and whether the SME holds a string.
    logic [7:0] sb [32];
    logic [7:0] pb [9];
    bit         loaded_m;
    int         n_checks = 0;
    int         n_pass   = 0;

    typedef struct {
        logic [5:0] slen;
        logic [3:0] plen;
        bit         send, stale, bstart, bcfg, vm;
        logic [4:0] vi;
        int         dly;
        int         ens, enp;
    } vec_t;
    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cfg_write(input bit sel, input logic [4:0] addr, input logic [7:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        tick();
        cfg_we = 1'b0;
        if (!sel) sb[addr] = data;
        else if (addr < 5'd9) pb[addr] = data;
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) cfg_write(1'b0, 5'(i), s[i]);
    endtask

    task automatic load_pat(input string s);
        for (int i = 0; i < s.len(); i++) cfg_write(1'b1, 5'(i), s[i]);
    endtask

    // One full transaction: start, observe the stream, answer with valid, check result.
    task automatic run_txn(input string name, input logic [5:0] slen, input logic [3:0] plen,
                           input bit send, input int exp_ns, input int exp_np,
                           input bit stale, input bit bstart, input bit bcfg,
                           input bit vm, input logic [4:0] vi, input int dly);
        int ns = 0, np = 0, bad = 0, both = 0, order = 0, early = 0;
        bit gap = 0, stale_done = 0;
        str_len = slen; pat_len = plen; send_str = send; start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, ".busy_rise"}, busy, 1);
        for (int k = 0; k < 64; k++) begin
            if (!isstring && !ispattern) begin
                gap = 1;
                break;
            end
            if (isstring && ispattern) both++;
            if (isstring) begin
                if (np != 0) order++;
                if (ns >= 32 || chardata !== sb[ns]) bad++;
                ns++;
            end else begin
                if (np >= 9 || chardata !== pb[np]) bad++;
                np++;
            end
            if (done) early++;
            if (stale && ispattern && !stale_done) begin
                valid = 1'b1; match = ~vm; match_index = vi ^ 5'd5; stale_done = 1;
            end
            if (bstart && k == 1) start = 1'b1;
            if (bcfg && k == 2) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 5'd0; cfg_data = ~sb[0];
            end
            tick();
            valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
        end
        chk({name, ".gap_seen"}, gap, 1);
        chk({name, ".str_chars"}, ns, exp_ns);
        chk({name, ".pat_chars"}, np, exp_np);
        chk({name, ".char_errs"}, bad, 0);
        chk({name, ".str_before_pat"}, order, 0);
        chk({name, ".both_high"}, both, 0);
        chk({name, ".gap_data"}, chardata, 0);
        tick();
        for (int d = 0; d < dly; d++) begin
            if (done || isstring || ispattern) early++;
            tick();
        end
        chk({name, ".wait_quiet"}, early, 0);
        valid = 1'b1; match = vm; match_index = vi;
        tick();
        valid = 1'b0;
        chk({name, ".done"}, {done, busy}, 2'b11);
        chk({name, ".res_match"}, res_match, vm);
        chk({name, ".res_index"}, res_index, vi);
        chk({name, ".res_timeout"}, res_timeout, 0);
        tick();
        chk({name, ".idle"}, {done, busy}, 2'b00);
        if (exp_ns > 0) loaded_m = 1;
        $display("txn %s: str_len=%0d pat_len=%0d send=%0d -> %0d str %0d pat chars, res %0d/%0d",
                 name, slen, plen, send, ns, np, res_match, res_index);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
        str_len = 0; pat_len = 0; send_str = 0; start = 0;
        match = 0; match_index = 0; valid = 0; loaded_m = 0;
        for (int i = 0; i < 32; i++) sb[i] = 8'h00;
        for (int i = 0; i < 9; i++) pb[i] = 8'h00;
        tick(); tick();
        chk("reset.outs", {busy, done, res_match, res_index, res_timeout, chardata, isstring, ispattern}, 0);
        rst = 1'b0;
        tick();

        // Spec test 1 and 2.
        load_str("ab cd");
        load_pat("cd");
        run_txn("t1", 6'd5, 4'd2, 1'b1, 5, 2, 0, 0, 0, 1'b1, 5'd3, 2);
        load_pat("^cd");
        run_txn("t2", 6'd5, 4'd3, 1'b0, 0, 3, 0, 0, 0, 1'b1, 5'd3, 0);

        // Reset in the middle of a transaction.
        str_len = 6'd10; pat_len = 4'd3; send_str = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("midreset.outs", {busy, done, res_match, res_index, chardata, isstring, ispattern}, 0);
        $display("txn midreset: reset asserted during string phase");
        tick();
        rst = 1'b0;
        loaded_m = 0;
        tick();
        // Spec test 3: string resent after reset despite send_str=0.
        run_txn("t3", 6'd5, 4'd3, 1'b0, 5, 3, 0, 0, 0, 1'b0, 5'd9, 1);

        // Fill both buffers completely for the table and random sections.
        for (int i = 0; i < 32; i++) cfg_write(1'b0, 5'(i), 8'($urandom_range(1, 255)));
        for (int i = 0; i < 9; i++) cfg_write(1'b1, 5'(i), 8'($urandom_range(1, 255)));

        tbl[0] = '{slen: 6'd5,  plen: 4'd2,  send: 1, stale: 1, bstart: 1, bcfg: 0, vm: 0, vi: 5'd7,  dly: 3, ens: 5,  enp: 2};
        tbl[1] = '{slen: 6'd0,  plen: 4'd12, send: 1, stale: 0, bstart: 0, bcfg: 1, vm: 1, vi: 5'd31, dly: 0, ens: 32, enp: 9};
        tbl[2] = '{slen: 6'd40, plen: 4'd0,  send: 1, stale: 0, bstart: 0, bcfg: 0, vm: 1, vi: 5'd0,  dly: 1, ens: 32, enp: 1};
        tbl[3] = '{slen: 6'd32, plen: 4'd9,  send: 0, stale: 0, bstart: 0, bcfg: 0, vm: 0, vi: 5'd16, dly: 4, ens: 0,  enp: 9};
        tbl[4] = '{slen: 6'd1,  plen: 4'd1,  send: 1, stale: 1, bstart: 1, bcfg: 0, vm: 1, vi: 5'd1,  dly: 2, ens: 1,  enp: 1};
        tbl[5] = '{slen: 6'd33, plen: 4'd15, send: 1, stale: 0, bstart: 0, bcfg: 1, vm: 0, vi: 5'd21, dly: 0, ens: 32, enp: 9};
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].slen, tbl[i].plen, tbl[i].send,
                    tbl[i].ens, tbl[i].enp, tbl[i].stale, tbl[i].bstart, tbl[i].bcfg,
                    tbl[i].vm, tbl[i].vi, tbl[i].dly);
        end

        // Randomized transactions against the length/resend rules.
        for (int r = 0; r < 25; r++) begin
            logic [5:0] sl;
            logic [3:0] pl;
            bit         sd;
            int         el, ep;
            for (int w = 0; w < 3; w++)
                cfg_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom));
            sl = 6'($urandom_range(0, 40));
            pl = 4'($urandom_range(0, 15));
            sd = 1'($urandom_range(0, 1));
            el = (sl == 0 || sl > 32) ? 32 : int'(sl);
            ep = (pl == 0) ? 1 : ((pl > 9) ? 9 : int'(pl));
            if (!(sd || !loaded_m)) el = 0;
            run_txn($sformatf("rnd%0d", r), sl, pl, sd, el, ep,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom), int'($urandom_range(0, 6)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
